// File: rtl/instr_sequencer_if.sv
// Decoder/program-memory side bundle for the instruction sequencer.
// The sequencer connects through the slave modport; the decoder/board side uses master.
interface instr_sequencer_if #(
    parameter int P_SIZE = 5
);
    logic              decWrite;
    logic              decBranch;
    logic              decWait;
    logic              decHalt;
    logic              zeroFlag;
    logic [P_SIZE-1:0] branchTarget;
    logic              demoSwitch;
    logic [P_SIZE-1:0] pcAddress;
    logic              irLoad;
    logic              writeReg;
    logic              flagLoad;
    logic              halted;
    logic [2:0]        stateOut;

    modport slave (
        input  decWrite, decBranch, decWait, decHalt, zeroFlag, branchTarget, demoSwitch,
        output pcAddress, irLoad, writeReg, flagLoad, halted, stateOut
    );

    modport master (
        output decWrite, decBranch, decWait, decHalt, zeroFlag, branchTarget, demoSwitch,
        input  pcAddress, irLoad, writeReg, flagLoad, halted, stateOut
    );
endinterface

// File: rtl/instr_sequencer.sv
// picoMIPS multi-cycle sequencer: owns the PC and steps FETCH/EXEC/WB, with
// branch-if-zero, a synchronised demo-switch WAIT and HALT.
module instr_sequencer #(
    parameter int P_SIZE      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    instr_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        EXEC    = 3'd1,
        WB      = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        HALT    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [P_SIZE-1:0]       pc_q, pc_d;
    logic                    taken_q, taken_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    sw_sync;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.demoSwitch};
    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            taken_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            sync_q  <= sync_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        taken_d      = taken_q;
        bus.irLoad   = 1'b0;
        bus.writeReg = 1'b0;
        bus.flagLoad = 1'b0;
        bus.halted   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.irLoad = 1'b1;
                state_d    = EXEC;
            end
            EXEC: begin
                // Branch outcome is captured here so zeroFlag may change before WB.
                taken_d = bus.decBranch & bus.zeroFlag;
                if (bus.decHalt)
                    state_d = HALT;
                else if (bus.decWait)
                    state_d = WAIT_HI;
                else
                    state_d = WB;
            end
            WB: begin
                bus.writeReg = bus.decWrite & ~bus.decBranch;
                bus.flagLoad = bus.decWrite & ~bus.decBranch;
                pc_d         = taken_q ? bus.branchTarget : pc_q + 1'b1;
                state_d      = FETCH;
            end
            WAIT_HI: begin
                if (sw_sync)
                    state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!sw_sync) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.pcAddress = pc_q;
    assign bus.stateOut  = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level model queues the
// expected per-cycle outputs, and a negedge monitor pops and compares them.
module tb_instr_sequencer;
    localparam int P = 5;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    instr_sequencer_if #(.P_SIZE(P)) bus();

    instr_sequencer #(.P_SIZE(P), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int st;
        int pc;
        bit ir;
        bit wr;
        bit fl;
        bit hl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   m_pc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 (cycle %0d)", cycle);
            end else begin
                mon_e = sb.pop_front();
                chk("stateOut",  {29'd0, bus.stateOut}, mon_e.st);
                chk("pcAddress", {27'd0, bus.pcAddress}, mon_e.pc);
                chk("irLoad",    {31'd0, bus.irLoad},   {31'd0, mon_e.ir});
                chk("writeReg",  {31'd0, bus.writeReg}, {31'd0, mon_e.wr});
                chk("flagLoad",  {31'd0, bus.flagLoad}, {31'd0, mon_e.fl});
                chk("halted",    {31'd0, bus.halted},   {31'd0, mon_e.hl});
            end
        end
    end

    task automatic rand_decode();
        bus.decWrite     = 1'($urandom_range(0, 1));
        bus.decBranch    = 1'($urandom_range(0, 1));
        bus.decWait      = 1'($urandom_range(0, 1));
        bus.decHalt      = 1'($urandom_range(0, 1));
        bus.zeroFlag     = 1'($urandom_range(0, 1));
        bus.branchTarget = P'($urandom_range(0, 31));
    endtask

    // kind: 0 normal, 1 branch, 2 wait, 3 halt (always left via reset).
    // rst_at: cycle offset within the instruction where reset is asserted, -1 for none.
    task automatic do_instr(input int kind, input int rst_at, input int wa, input int wh,
                            input int hc, input int tgt_in, input int zf_in, input int dw_in);
        int seq[$];
        bit dw, db, dwt, dh, zf, taken, rst;
        int tgt, last_rst;
        exp_t e;
        dh  = (kind == 3);
        dwt = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
        db  = (kind == 1) || (kind >= 2 && $urandom_range(0, 1) == 1);
        dw  = (dw_in < 0) ? 1'($urandom_range(0, 1)) : 1'(dw_in);
        zf  = (zf_in < 0) ? 1'($urandom_range(0, 1)) : 1'(zf_in);
        tgt = (tgt_in < 0) ? int'($urandom_range(0, 31)) : tgt_in;
        taken = (kind == 1) && zf;

        seq.push_back(0);
        seq.push_back(1);
        if (kind <= 1) seq.push_back(2);
        if (kind == 2) begin
            repeat (wa + S - 1) seq.push_back(3);
            repeat (wh) seq.push_back(4);
        end
        if (kind == 3) repeat (hc) seq.push_back(5);
        last_rst = (kind == 3) ? seq.size() - 1 : rst_at;

        for (int off = 0; off < seq.size(); off++) begin
            rst = (off == last_rst);
            reset = rst;
            if (off == 0 || (kind == 3 && off >= 2)) begin
                rand_decode();
            end else begin
                bus.decWrite     = dw;
                bus.decBranch    = db;
                bus.decWait      = dwt;
                bus.decHalt      = dh;
                bus.branchTarget = P'(tgt);
                bus.zeroFlag     = (off == 1) ? zf : 1'($urandom_range(0, 1));
            end
            if (kind == 2)
                bus.demoSwitch = (off >= wa) && (off < wa + wh);
            else if (kind == 3 && off >= 2)
                bus.demoSwitch = 1'($urandom_range(0, 1));
            else
                bus.demoSwitch = 1'b0;
            if (rst) bus.demoSwitch = 1'b0;

            e.st = seq[off];
            e.pc = m_pc;
            e.ir = (seq[off] == 0);
            e.wr = (seq[off] == 2) && dw && !db;
            e.fl = e.wr;
            e.hl = (seq[off] == 5);
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (rst) begin
                reset = 1'b0;
                m_pc  = 0;
                return;
            end
        end

        if (kind == 1 && taken) m_pc = tgt;
        else                    m_pc = (m_pc + 1) % 32;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, kind, ra, wa, wh, hc;
        reset          = 1'b1;
        bus.decWrite   = 1'b0;
        bus.decBranch  = 1'b0;
        bus.decWait    = 1'b0;
        bus.decHalt    = 1'b0;
        bus.zeroFlag   = 1'b0;
        bus.branchTarget = '0;
        bus.demoSwitch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_pc   = 0;
        mon_en = 1'b1;

        repeat (3) do_instr(0, -1, 0, 0, 0, -1, -1, 1);
        do_instr(1, -1, 0, 0, 0, 31, 1, -1);
        do_instr(0, -1, 0, 0, 0, -1, -1, 1);
        do_instr(1, -1, 0, 0, 0, 4, 1, 1);
        do_instr(1, -1, 0, 0, 0, 20, 0, 1);
        do_instr(1, -1, 0, 0, 0, 17, 1, -1);
        do_instr(1, -1, 0, 0, 0, 6, 1, -1);
        do_instr(2, -1, 3, 10, 0, -1, -1, 1);
        do_instr(1, -1, 0, 0, 0, 9, 1, -1);
        do_instr(3, -1, 0, 0, 51, -1, -1, -1);
        do_instr(0, -1, 0, 0, 0, -1, -1, 1);
        do_instr(0, 2, 0, 0, 0, -1, -1, 1);
        do_instr(0, -1, 0, 0, 0, -1, -1, 1);
        do_instr(2, S + 3, 2, 4, 0, -1, -1, 1);
        do_instr(2, -1, 0, 1, 0, -1, -1, -1);

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            kind = (r <= 3) ? 0 : (r <= 6) ? 1 : (r <= 8) ? 2 : 3;
            wa = $urandom_range(0, 4);
            wh = $urandom_range(1, 10);
            hc = $urandom_range(2, 20);
            ra = -1;
            if ($urandom_range(0, 9) == 0) begin
                if (kind == 2) ra = $urandom_range(0, wa + S + wh);
                else           ra = $urandom_range(0, 2);
            end
            do_instr(kind, ra, wa, wh, hc, -1, -1, -1);
        end

        @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
